// File: rtl/tape_mem_arbiter.sv
// Two-port read arbiter sharing one byte-wide SDRAM read port.
// Issues a one-cycle read strobe, waits LATENCY cycles, returns data with a one-cycle ack.
module tape_mem_arbiter #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LATENCY    = 2,   // legal range 1..15
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] dout0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] dout1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              grant_q, last_grant_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] dout0_q, dout1_q;
    logic              any_req;
    logic              sel;

    // Tie goes to port 0 under fixed priority, otherwise to the port not served last.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            sel = req1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == 4'd0) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= 4'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            dout0_q      <= '0;
            dout1_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        mem_addr_q   <= sel ? addr1 : addr0;
                        grant_q      <= sel;
                        last_grant_q <= sel;
                    end
                end
                StIssue: cnt_q <= 4'(LATENCY - 1);
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        if (grant_q) begin
                            dout1_q <= mem_data;
                        end else begin
                            dout0_q <= mem_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A requester that dropped its req before the ack cycle gets no ack.
    always_comb begin
        mem_rd = (state_q == StIssue);
        busy   = (state_q != StIdle);
        ack0   = (state_q == StAck) && !grant_q && req0;
        ack1   = (state_q == StAck) && grant_q && req1;
    end

    assign mem_addr = mem_addr_q;
    assign grant    = grant_q;
    assign dout0    = dout0_q;
    assign dout1    = dout1_q;

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Bench for tape_mem_arbiter: three instances (L=2 RR, L=2 fixed prio, L=1 RR) on shared
// requester inputs, each checked every cycle against a transaction-offset model.
module tb_tape_mem_arbiter;
    localparam int AW = 25;
    localparam int DW = 8;
    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] mem_d [ND];
    logic [ND-1:0] ack0_w, ack1_w, rd_w, busy_w, grant_w;
    logic [AW-1:0] maddr_w [ND];
    logic [DW-1:0] dout0_w [ND];
    logic [DW-1:0] dout1_w [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        tape_mem_arbiter #(
            .ADDR_W    (AW),
            .DATA_W    (DW),
            .LATENCY   ((g == 2) ? 1 : 2),
            .FIXED_PRIO(g == 1)
        ) u (
            .clk     (clk),
            .reset_n (reset_n),
            .req0    (req0),
            .addr0   (addr0),
            .ack0    (ack0_w[g]),
            .dout0   (dout0_w[g]),
            .req1    (req1),
            .addr1   (addr1),
            .ack1    (ack1_w[g]),
            .dout1   (dout1_w[g]),
            .mem_addr(maddr_w[g]),
            .mem_rd  (rd_w[g]),
            .mem_data(mem_d[g]),
            .busy    (busy_w[g]),
            .grant   (grant_w[g])
        );
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: a transaction is an offset from its issue cycle (0 issue, 1..L wait, L+1 ack).
    bit            m_act [ND];
    int            m_off [ND];
    bit            m_port[ND];
    bit            m_last[ND];
    logic [AW-1:0] m_addr[ND];
    logic [DW-1:0] m_d0  [ND];
    logic [DW-1:0] m_d1  [ND];

    // Memory: returns memf(addr) exactly L cycles after the strobe, junk otherwise.
    bit            rd_seen  [ND];
    logic [AW-1:0] addr_seen[ND];
    bit            pend     [ND];
    int            cd       [ND];
    logic [AW-1:0] paddr    [ND];

    int            rd_n[ND], ack0_n[ND], ack1_n[ND];
    int            rd_cyc  [ND][32];
    logic [AW-1:0] rd_addr [ND][32];
    int            ack0_cyc[ND][32];
    logic [DW-1:0] ack0_dat[ND][32];

    function automatic int lat_of(int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic bit fp_of(int i);
        return i == 1;
    endfunction

    function automatic logic [DW-1:0] memf(logic [AW-1:0] a);
        return a[7:0] + 8'h82;
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc%0d: got 0x%0h, want 0x%0h", name, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_act[i]  = 1'b0;
            m_off[i]  = 0;
            m_port[i] = 1'b0;
            m_last[i] = 1'b1;
            m_addr[i] = '0;
            m_d0[i]   = '0;
            m_d1[i]   = '0;
        end
    endtask

    task automatic mem_reset();
        for (int i = 0; i < ND; i++) begin
            rd_seen[i] = 1'b0;
            pend[i]    = 1'b0;
            cd[i]      = 0;
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < ND; i++) begin
            rd_n[i]   = 0;
            ack0_n[i] = 0;
            ack1_n[i] = 0;
        end
    endtask

    task automatic model_step();
        bit p;
        for (int i = 0; i < ND; i++) begin
            if (!m_act[i]) begin
                if (req0 || req1) begin
                    if (req0 && req1) p = fp_of(i) ? 1'b0 : ~m_last[i];
                    else p = req1;
                    m_act[i]  = 1'b1;
                    m_off[i]  = 0;
                    m_port[i] = p;
                    m_last[i] = p;
                    m_addr[i] = p ? addr1 : addr0;
                end
            end else begin
                if (m_off[i] == lat_of(i)) begin
                    if (m_port[i]) m_d1[i] = memf(m_addr[i]);
                    else m_d0[i] = memf(m_addr[i]);
                end
                if (m_off[i] == lat_of(i) + 1) m_act[i] = 1'b0;
                else m_off[i]++;
            end
        end
    endtask

    task automatic mem_drive();
        for (int i = 0; i < ND; i++) begin
            if (rd_seen[i]) begin
                pend[i]  = 1'b1;
                cd[i]    = lat_of(i) - 1;
                paddr[i] = addr_seen[i];
            end
            if (pend[i] && cd[i] == 0) begin
                mem_d[i] = memf(paddr[i]);
                pend[i]  = 1'b0;
            end else if (pend[i]) begin
                cd[i]--;
                mem_d[i] = memf(paddr[i]) ^ 8'($urandom_range(1, 255));
            end else begin
                mem_d[i] = 8'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_step();
        cyc++;
        #1;
        mem_drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        model_reset();
        mem_reset();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic async_reset_pulse();
        #2;
        reset_n = 1'b0;
        model_reset();
        mem_reset();
    endtask

    // Compare process: every output of every instance, every cycle.
    bit exp_ack;
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            exp_ack = m_act[i] && (m_off[i] == lat_of(i) + 1);
            chk("busy", i, 32'(busy_w[i]), 32'(m_act[i]));
            chk("mem_rd", i, 32'(rd_w[i]), 32'(m_act[i] && m_off[i] == 0));
            chk("mem_addr", i, 32'(maddr_w[i]), 32'(m_addr[i]));
            chk("grant", i, 32'(grant_w[i]), 32'(m_port[i]));
            chk("ack0", i, 32'(ack0_w[i]), 32'(exp_ack && !m_port[i] && req0));
            chk("ack1", i, 32'(ack1_w[i]), 32'(exp_ack && m_port[i] && req1));
            chk("dout0", i, 32'(dout0_w[i]), 32'(m_d0[i]));
            chk("dout1", i, 32'(dout1_w[i]), 32'(m_d1[i]));
            if (rd_w[i]) begin
                if (rd_n[i] < 32) begin
                    rd_cyc[i][rd_n[i]]  = cyc;
                    rd_addr[i][rd_n[i]] = maddr_w[i];
                end
                rd_n[i]++;
            end
            if (ack0_w[i]) begin
                if (ack0_n[i] < 32) begin
                    ack0_cyc[i][ack0_n[i]] = cyc;
                    ack0_dat[i][ack0_n[i]] = dout0_w[i];
                end
                ack0_n[i]++;
            end
            if (ack1_w[i]) ack1_n[i]++;
            rd_seen[i]   = rd_w[i];
            addr_seen[i] = maddr_w[i];
        end
    end

    int c0;
    int prev;
    initial begin
        model_reset();
        mem_reset();
        clear_logs();
        for (int i = 0; i < ND; i++) mem_d[i] = '0;

        // Single read on port 0.
        do_reset();
        clear_logs();
        step();
        c0 = cyc;
        req0 = 1'b1;
        addr0 = AW'(32'h123);
        repeat (5) step();
        req0 = 1'b0;
        repeat (8) step();
        chk("single_rd_cyc", 0, 32'(rd_cyc[0][0]), 32'(c0 + 1));
        chk("single_rd_addr", 0, 32'(rd_addr[0][0]), 32'h123);
        chk("single_rd_count", 0, 32'(rd_n[0]), 32'd1);
        chk("single_ack_cyc", 0, 32'(ack0_cyc[0][0]), 32'(c0 + 4));
        chk("single_ack_data", 0, 32'(ack0_dat[0][0]), 32'hA5);
        chk("single_ack1_none", 0, 32'(ack1_n[0]), 32'd0);
        chk("single_ack_cyc_l1", 2, 32'(ack0_cyc[2][0]), 32'(c0 + 3));

        // Tie: round-robin alternates, fixed priority sticks to port 0.
        do_reset();
        clear_logs();
        step();
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = AW'(32'h10);
        addr1 = AW'(32'h20);
        repeat (22) step();
        for (int k = 0; k < 4; k++) begin
            chk("rr_addr", 0, 32'(rd_addr[0][k]), (k % 2 == 1) ? 32'h20 : 32'h10);
            if (k > 0) chk("rr_spacing", 0, 32'(rd_cyc[0][k] - rd_cyc[0][k-1]), 32'd5);
            chk("fp_addr", 1, 32'(rd_addr[1][k]), 32'h10);
        end
        chk("fp_no_ack1", 1, 32'(ack1_n[1]), 32'd0);
        req0 = 1'b0;
        repeat (12) step();
        chk("fp_port1_served", 1, 32'(rd_addr[1][rd_n[1]-1]), 32'h20);
        chk("fp_port1_acked", 1, 32'(ack1_n[1] > 0), 32'd1);
        req1 = 1'b0;
        repeat (8) step();

        // Back-to-back stream on port 0, address advanced on each ack.
        clear_logs();
        step();
        req0 = 1'b1;
        addr0 = AW'(32'h7F);
        prev = 0;
        for (int k = 0; k < 60 && ack0_n[0] < 4; k++) begin
            step();
            if (ack0_n[0] != prev) begin
                prev = ack0_n[0];
                if (prev >= 4) req0 = 1'b0;
                else addr0 = addr0 + AW'(1);
            end
        end
        req0 = 1'b0;
        repeat (8) step();
        chk("stream_acks", 0, 32'(ack0_n[0]), 32'd4);
        chk("stream_reads", 0, 32'(rd_n[0]), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("stream_data", 0, 32'(ack0_dat[0][k]), 32'(k + 1));
            chk("stream_addr", 0, 32'(rd_addr[0][k]), 32'(32'h7F + k));
        end

        // Port 1 abandons its request during WAIT.
        clear_logs();
        step();
        req1 = 1'b1;
        addr1 = AW'(32'h55);
        step();
        step();
        req1 = 1'b0;
        repeat (4) step();
        for (int i = 0; i < ND; i++) begin
            chk("abandon_no_ack1", i, 32'(ack1_n[i]), 32'd0);
            chk("abandon_dout1", i, 32'(dout1_w[i]), 32'hD7);
            chk("abandon_idle", i, 32'(busy_w[i]), 32'd0);
        end

        // Asynchronous reset mid-WAIT, then first tie must go to port 0.
        step();
        req0 = 1'b1;
        addr0 = AW'(32'h33);
        step();
        step();
        chk("pre_reset_busy", 0, 32'(busy_w[0]), 32'd1);
        async_reset_pulse();
        #1;
        for (int i = 0; i < ND; i++) begin
            chk("arst_mem_rd", i, 32'(rd_w[i]), 32'd0);
            chk("arst_busy", i, 32'(busy_w[i]), 32'd0);
            chk("arst_acks", i, 32'({ack0_w[i], ack1_w[i]}), 32'd0);
            chk("arst_dout0", i, 32'(dout0_w[i]), 32'd0);
            chk("arst_dout1", i, 32'(dout1_w[i]), 32'd0);
        end
        step();
        reset_n = 1'b1;
        clear_logs();
        c0 = cyc;
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = AW'(32'h10);
        addr1 = AW'(32'h20);
        repeat (6) step();
        chk("post_rst_tie", 0, 32'(rd_addr[0][0]), 32'h10);
        chk("post_rst_ack_cyc", 0, 32'(ack0_cyc[0][0]), 32'(c0 + 4));
        chk("post_rst_ack_l1", 2, 32'(ack0_cyc[2][0]), 32'(c0 + 3));
        chk("post_rst_data_l1", 2, 32'(ack0_dat[2][0]), 32'h92);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (8) step();

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            step();
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            if ($urandom_range(0, 7) == 0) addr0 = AW'($urandom);
            if ($urandom_range(0, 7) == 0) addr1 = AW'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                async_reset_pulse();
                step();
                reset_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tape_mem_arbiter.md
Name: tape_mem_arbiter

Overview:
- Shares the single byte-wide SDRAM read port between two requesters.
- Port 0 is the cassette playback reader. Port 1 is an auxiliary reader, such as a ROM or tape-image inspector.
- Each port uses a req/ack handshake and gets its read data with the ack.
- The block issues one-cycle read strobes to the memory and captures data after a fixed latency.

Parameters:
ADDR_W, 25, address width of requester and memory ports
DATA_W, 8, data width
LATENCY, 2, cycles from mem_rd strobe to valid mem_data; legal range 1..15
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req0  in  1  port 0 read request, level
addr0  in  ADDR_W  port 0 byte address, held stable while req0=1
ack0  out  1  one-cycle pulse: dout0 valid
dout0  out  DATA_W  port 0 read data, held until next ack0
req1  in  1  port 1 read request, level
addr1  in  ADDR_W  port 1 byte address
ack1  out  1  one-cycle pulse: dout1 valid
dout1  out  DATA_W  port 1 read data, held until next ack1
mem_addr  out  ADDR_W  memory address, registered
mem_rd  out  1  one-cycle read strobe
mem_data  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE
grant  out  1  index of the port owning the current or last transaction

Behaviour:
- Reset is asynchronous and active-low: clock is clk, reset is reset_n; asserting reset_n=0 forces all state immediately.
- Reset values:
  - state=IDLE
  - mem_rd=0, mem_addr=0
  - ack0=ack1=0, dout0=dout1=0
  - busy=0, grant=0
  - last_grant=1, so port 0 wins the first tie
  - latency counter=0
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Samples req0/req1.
  - Neither high: stay in IDLE.
  - One high: grant it.
  - Both high, FIXED_PRIO=1: grant port 0.
  - Both high, FIXED_PRIO=0: grant the port not equal to last_grant.
  - On a grant: latch the address into mem_addr, set grant and last_grant, go to ISSUE.
- ISSUE (cycle T):
  - mem_rd=1 for exactly this cycle.
  - Counter loaded with LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At the clock edge ending cycle T+LATENCY, capture mem_data into dout[grant] and go to ACK.
  - LATENCY=1 spends exactly one cycle in WAIT.
- ACK (cycle T+LATENCY+1):
  - ack[grant]=1 for one cycle; the other ack stays 0.
  - Go to IDLE.
- Latency figures:
  - req sampled at cycle N gives mem_rd at N+1 and ack at N+1+LATENCY+1.
  - Minimum issue-to-issue spacing is LATENCY+3 cycles.
- Requester protocol:
  - Requester must hold req and addr stable until its ack.
  - It may keep req high after ack with a new address for back-to-back reads.
  - The arbiter re-samples in IDLE, the cycle after ACK, so no duplicate grant arises from a stale req.
- req dropped mid-transaction:
  - The transaction still completes and dout is updated, but ack is suppressed.
  - The ack is suppressed when req[grant]=0 in the ACK cycle.
- Address changes mid-transaction are ignored, because mem_addr is already latched.
- A request arriving during ISSUE/WAIT/ACK is held pending by its level and served at the next IDLE.
- Round-robin fairness: with both req held high continuously, grants alternate 0,1,0,1 (FIXED_PRIO=0).
- Asserting reset mid-transaction aborts it:
  - mem_rd and acks drop immediately.
  - No data is captured.
  - The next transaction after release starts from IDLE.
- mem_data is sampled only at the WAIT-exit edge and ignored at all other times.
- busy=1 exactly in ISSUE, WAIT and ACK.

Test Plan:
- Single read: LATENCY=2, req0=1, addr0=0x000123, memory returns 0xA5 two cycles after mem_rd -> mem_rd pulses one cycle with mem_addr=0x000123, ack0 pulses 4 cycles after req0 sampled, dout0=0xA5, ack1 stays 0.
- Tie round-robin: req0=req1=1 continuously from reset, addr0=0x10, addr1=0x20 -> mem_addr sequence 0x10,0x20,0x10,0x20, grant 0,1,0,1, issue spacing 5 cycles.
- Fixed priority: FIXED_PRIO=1, both req held -> port 0 is granted every time and ack1 never pulses while req0 stays high; after req0 drops, port 1 is served at the next IDLE.
- Back-to-back port 0 stream: req0 held high, addr0 incremented on each ack0, 4 reads returning 0x01..0x04 -> dout0 captures 0x01..0x04 in order, exactly 4 ack0 pulses, no repeated address.
- Abandoned request: req1 dropped during WAIT -> the transaction completes, dout1 is updated, ack1 stays 0, and the arbiter returns to IDLE with busy=0.
- Async reset mid-WAIT: reset_n=0 asynchronously -> mem_rd=0, busy=0, acks=0 and douts=0 immediately; after release, the first tie goes to port 0; LATENCY=1 variant gives ack 3 cycles after req sampled.
